// File: rtl/dmem_arbiter_if.sv
// Requester-side req/ack bundle, one instance each for the cpu and debug ports.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// Every transaction runs IDLE -> ACCESS -> DONE; all outputs come from flops.
module dmem_arbiter #(
    parameter int MEM_WORDS  = 256,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave cpu,
    dmem_arbiter_if.slave dbg,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e      state_q;
    logic        gnt_dbg_q;
    logic        last_dbg_q;
    logic        we_q;
    logic        err_q;
    logic        busy_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        cpu_ack_q;
    logic        cpu_err_q;
    logic [31:0] cpu_rdata_q;
    logic        dbg_ack_q;
    logic        dbg_err_q;
    logic [31:0] dbg_rdata_q;

    logic        gnt_dbg_d;
    logic        we_d;
    logic        err_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;

    // dbg wins alone, or on a tie when round-robin says it is dbg's turn
    always_comb begin
        gnt_dbg_d = dbg.req & (~cpu.req | (~FIXED_PRIO & ~last_dbg_q));
        we_d      = gnt_dbg_d ? dbg.we    : cpu.we;
        addr_d    = gnt_dbg_d ? dbg.addr  : cpu.addr;
        wdata_d   = gnt_dbg_d ? dbg.wdata : cpu.wdata;
        err_d     = (addr_d[1:0] != 2'b00) |
                    ({2'b00, addr_d[31:2]} >= 32'(MEM_WORDS));
        rdata_d   = (~err_q & ~we_q) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_dbg_q   <= 1'b0;
            last_dbg_q  <= 1'b1;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu.req | dbg.req) begin
                        state_q     <= ACCESS;
                        busy_q      <= 1'b1;
                        gnt_dbg_q   <= gnt_dbg_d;
                        last_dbg_q  <= gnt_dbg_d;
                        we_q        <= we_d;
                        err_q       <= err_d;
                        mem_read_q  <= ~err_d & ~we_d;
                        mem_write_q <= ~err_d & we_d;
                        mem_addr_q  <= err_d ? '0 : addr_d;
                        mem_wdata_q <= err_d ? '0 : wdata_d;
                    end
                end
                ACCESS: begin
                    state_q     <= DONE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    cpu_ack_q   <= ~gnt_dbg_q;
                    cpu_err_q   <= ~gnt_dbg_q & err_q;
                    cpu_rdata_q <= gnt_dbg_q ? '0 : rdata_d;
                    dbg_ack_q   <= gnt_dbg_q;
                    dbg_err_q   <= gnt_dbg_q & err_q;
                    dbg_rdata_q <= gnt_dbg_q ? rdata_d : '0;
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    cpu_ack_q   <= 1'b0;
                    cpu_err_q   <= 1'b0;
                    cpu_rdata_q <= '0;
                    dbg_ack_q   <= 1'b0;
                    dbg_err_q   <= 1'b0;
                    dbg_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cpu.ack   = cpu_ack_q;
    assign cpu.err   = cpu_err_q;
    assign cpu.rdata = cpu_rdata_q;
    assign dbg.ack   = dbg_ack_q;
    assign dbg.err   = dbg_err_q;
    assign dbg.rdata = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model plus directed
// scenarios and randomized two-requester traffic.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic        ack_v   [2];
    logic        err_v   [2];
    logic [31:0] rdata_v [2];

    dmem_arbiter_if cpu_if ();
    dmem_arbiter_if dbg_if ();

    assign cpu_if.req   = req_v[0];
    assign cpu_if.we    = we_v[0];
    assign cpu_if.addr  = addr_v[0];
    assign cpu_if.wdata = wdata_v[0];
    assign dbg_if.req   = req_v[1];
    assign dbg_if.we    = we_v[1];
    assign dbg_if.addr  = addr_v[1];
    assign dbg_if.wdata = wdata_v[1];
    assign ack_v[0]     = cpu_if.ack;
    assign err_v[0]     = cpu_if.err;
    assign rdata_v[0]   = cpu_if.rdata;
    assign ack_v[1]     = dbg_if.ack;
    assign err_v[1]     = dbg_if.err;
    assign rdata_v[1]   = dbg_if.rdata;

    logic        mem_read;
    logic        mem_write;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [256];

    dmem_arbiter #(.MEM_WORDS(256), .FIXED_PRIO(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu_if),
        .dbg      (dbg_if),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:2]] : 32'hBAD0BAD0;
    always @(posedge clk)
        if (mem_write && mem_addr < 32'd1024) mem[mem_addr[9:2]] <= mem_wdata;

    // fixed-priority instance: both sides request reads continuously
    logic           p1_req;
    dmem_arbiter_if p1c ();
    dmem_arbiter_if p1d ();
    assign p1c.req   = p1_req;
    assign p1c.we    = 1'b0;
    assign p1c.addr  = 32'h0;
    assign p1c.wdata = 32'h0;
    assign p1d.req   = p1_req;
    assign p1d.we    = 1'b0;
    assign p1d.addr  = 32'h4;
    assign p1d.wdata = 32'h0;

    logic        p1_mr;
    logic        p1_mw;
    logic        p1_busy;
    logic [31:0] p1_ma;
    logic [31:0] p1_mwd;

    dmem_arbiter #(.MEM_WORDS(256), .FIXED_PRIO(1'b1)) dut_p1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (p1c),
        .dbg      (p1d),
        .mem_read (p1_mr),
        .mem_write(p1_mw),
        .mem_addr (p1_ma),
        .mem_wdata(p1_mwd),
        .mem_rdata(32'h0),
        .busy     (p1_busy)
    );

    function automatic logic [31:0] pre(input int i);
        return (i == 8) ? 32'h0 : (32'hC0DE0000 | 32'(i));
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, strobe one cycle after the
    // grant, ack two cycles after; the cycle after the ack is idle again.
    logic [31:0] gmem [256];
    bit          m_act = 1'b0;
    bit          m_last_dbg = 1'b1;
    bit          m_we;
    bit          m_err;
    int          m_ph;
    int          m_side;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        e_ack [2];
    logic        e_err [2];
    logic [31:0] e_rd  [2];
    logic        e_busy;
    logic        e_mr;
    logic        e_mw;
    logic [31:0] e_ma;
    logic [31:0] e_mwd;
    int          n_cpu_ack = 0;
    int          n_wr = 0;
    int          n_strobe = 0;

    initial forever begin
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            e_ack[s] = 1'b0;
            e_err[s] = 1'b0;
            e_rd[s]  = 32'h0;
        end
        e_busy = 1'b0;
        e_mr   = 1'b0;
        e_mw   = 1'b0;
        e_ma   = 32'h0;
        e_mwd  = 32'h0;
        if (!rst_n) begin
            m_act      = 1'b0;
            m_last_dbg = 1'b1;
        end else if (m_act) begin
            m_ph++;
            e_busy = 1'b1;
            if (m_ph == 1 && !m_err) begin
                e_mr  = !m_we;
                e_mw  = m_we;
                e_ma  = m_addr;
                e_mwd = m_wdata;
                if (m_we) gmem[m_addr[9:2]] = m_wdata;
                else m_rdata = gmem[m_addr[9:2]];
            end
            if (m_ph == 2) begin
                e_ack[m_side] = 1'b1;
                e_err[m_side] = m_err;
                e_rd[m_side]  = m_rdata;
                m_act = 1'b0;
            end
        end else if (req_v[0] || req_v[1]) begin
            if (req_v[0] && req_v[1]) m_side = m_last_dbg ? 0 : 1;
            else m_side = req_v[1] ? 1 : 0;
            m_last_dbg = (m_side == 1);
            m_we    = we_v[m_side];
            m_addr  = addr_v[m_side];
            m_wdata = wdata_v[m_side];
            m_err   = (m_addr % 4 != 0) || (m_addr / 4 >= 256);
            m_rdata = 32'h0;
            m_ph    = 0;
            m_act   = 1'b1;
        end
        chk1("cpu_ack", cpu_if.ack, e_ack[0]);
        chk1("cpu_err", cpu_if.err, e_err[0]);
        chk32("cpu_rdata", cpu_if.rdata, e_rd[0]);
        chk1("dbg_ack", dbg_if.ack, e_ack[1]);
        chk1("dbg_err", dbg_if.err, e_err[1]);
        chk32("dbg_rdata", dbg_if.rdata, e_rd[1]);
        chk1("busy", busy, e_busy);
        chk1("mem_read", mem_read, e_mr);
        chk1("mem_write", mem_write, e_mw);
        chk32("mem_addr", mem_addr, e_ma);
        chk32("mem_wdata", mem_wdata, e_mwd);
        if (cpu_if.ack) n_cpu_ack++;
        if (mem_write) n_wr++;
        if (mem_read || mem_write) n_strobe++;
    end

    task automatic wait_ack(input int s, output bit got, output int ac,
                            output logic [31:0] rd, output logic er);
        got = 1'b0;
        ac  = 0;
        rd  = 32'h0;
        er  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_v[s]) begin
                got = 1'b1;
                ac  = cyc;
                rd  = rdata_v[s];
                er  = err_v[s];
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack timeout: side %0d got no ack, want one (cycle %0d)", s, cyc);
        end
    endtask

    task automatic txn(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int rc, output int ac,
                       output logic [31:0] rd, output logic er);
        bit got;
        @(posedge clk);
        #1;
        req_v[s]   = 1'b1;
        we_v[s]    = w;
        addr_v[s]  = a;
        wdata_v[s] = d;
        rc = cyc;
        wait_ack(s, got, ac, rd, er);
        @(posedge clk);
        #1;
        req_v[s] = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if (r == 7) a[1:0] = 2'($urandom_range(1, 3));
        else if (r == 8) a = 32'h400 + ($urandom_range(0, 255) << 2);
        else if (r == 9) a = $urandom();
        return a;
    endfunction

    task automatic agent(input int s, input int n);
        bit hold;
        bit got;
        int ac;
        logic [31:0] rd;
        logic er;
        hold = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (!hold) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                @(posedge clk);
                #1;
            end
            req_v[s]   = 1'b1;
            we_v[s]    = 1'($urandom_range(0, 1));
            addr_v[s]  = rnd_addr();
            wdata_v[s] = $urandom();
            wait_ack(s, got, ac, rd, er);
            @(posedge clk);
            #1;
            hold = ($urandom_range(0, 1) == 1) && (k < n - 1);
            if (!hold) req_v[s] = 1'b0;
        end
        req_v[s] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int          rc0, ac0, rc1, ac1, a0, w0, s0, p1c_n, p1d_n, p1_rd_n, p1_busy_n;
        logic [31:0] rd0, rd1;
        logic        er0, er1;
        bit          got;
        int          gq[$];

        for (int s = 0; s < 2; s++) begin
            req_v[s]   = 1'b0;
            we_v[s]    = 1'b0;
            addr_v[s]  = 32'h0;
            wdata_v[s] = 32'h0;
        end
        p1_req = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = pre(i);
            gmem[i] = pre(i);
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // tie from reset: round-robin alternates, fixed priority starves dbg
        @(posedge clk);
        #1;
        req_v[0]  = 1'b1;
        addr_v[0] = 32'h0;
        req_v[1]  = 1'b1;
        addr_v[1] = 32'h4;
        p1_req    = 1'b1;
        p1c_n = 0;
        p1d_n = 0;
        p1_rd_n = 0;
        p1_busy_n = 0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_if.ack) gq.push_back(0);
            if (dbg_if.ack) gq.push_back(1);
            if (p1c.ack) p1c_n++;
            if (p1d.ack) p1d_n++;
            if (p1_mr) p1_rd_n++;
            if (p1_busy) p1_busy_n++;
            chk1("T2 p1 mem_write", p1_mw, 1'b0);
            chk32("T2 p1 mem_addr", p1_ma, 32'h0);
            chk32("T2 p1 mem_wdata", p1_mwd, 32'h0);
        end
        @(posedge clk);
        #1;
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        p1_req   = 1'b0;
        chk32("T2 grant count", gq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk32("T2 grant order", (i < gq.size()) ? gq[i] : 9, i % 2);
        chk32("T2 prio cpu grants", p1c_n, 4);
        chk32("T2 prio dbg grants", p1d_n, 0);
        chk32("T2 prio read strobes", p1_rd_n, 4);
        chk32("T2 prio busy cycles", p1_busy_n, 8);

        // write then read back through the cpu port
        w0 = n_wr;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rc0, ac0, rd0, er0);
        chk32("T1 write pulses", n_wr - w0, 1);
        chk32("T1 write ack cycle", ac0 - rc0 + 1, 3);
        chk32("T1 write rdata", rd0, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, rc0, ac0, rd0, er0);
        chk32("T1 read rdata", rd0, 32'hDEADBEEF);
        chk1("T1 read err", er0, 1'b0);
        chk32("T1 read ack cycle", ac0 - rc0 + 1, 3);

        // misaligned and out-of-range addresses never touch memory
        s0 = n_strobe;
        txn(1, 1'b0, 32'h13, 32'h0, rc0, ac0, rd0, er0);
        chk1("T3 misaligned err", er0, 1'b1);
        chk32("T3 misaligned rdata", rd0, 32'h0);
        txn(1, 1'b0, 32'h400, 32'h0, rc0, ac0, rd0, er0);
        chk1("T3 range err", er0, 1'b1);
        chk32("T3 range rdata", rd0, 32'h0);
        chk32("T3 strobes", n_strobe - s0, 0);

        // reset during the write's ACCESS cycle aborts it
        a0 = n_cpu_ack;
        @(posedge clk);
        #1;
        req_v[0]   = 1'b1;
        we_v[0]    = 1'b1;
        addr_v[0]  = 32'h20;
        wdata_v[0] = 32'h55;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        req_v[0] = 1'b0;
        @(negedge clk);
        chk1("T4 mem_write in reset", mem_write, 1'b0);
        chk1("T4 busy in reset", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk32("T4 acks after abort", n_cpu_ack - a0, 0);
        txn(0, 1'b0, 32'h20, 32'h0, rc0, ac0, rd0, er0);
        chk32("T4 read after abort", rd0, 32'h0);
        chk1("T4 read err", er0, 1'b0);

        // back-to-back stream with req held high
        @(posedge clk);
        #1;
        req_v[0]  = 1'b1;
        we_v[0]   = 1'b0;
        addr_v[0] = 32'h0;
        rc0 = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_ack(0, got, ac0, rd0, er0);
            chk32("T5 ack cycle", ac0 - rc0 + 1, 3 * (i + 1));
            chk32("T5 rdata", rd0, pre(i));
            @(posedge clk);
            #1;
            if (i < 2) addr_v[0] = 32'(4 * (i + 1));
            else req_v[0] = 1'b0;
        end

        // dbg arrives while cpu is in ACCESS and is served right after
        fork
            txn(0, 1'b0, 32'h4, 32'h0, rc0, ac0, rd0, er0);
            begin
                @(posedge clk);
                txn(1, 1'b0, 32'h8, 32'h0, rc1, ac1, rd1, er1);
            end
        join
        chk32("T6 dbg req offset", rc1 - rc0, 1);
        chk32("T6 cpu ack cycle", ac0 - rc0 + 1, 3);
        chk32("T6 dbg ack cycle", ac1 - rc0 + 1, 6);
        chk32("T6 cpu rdata", rd0, pre(1));
        chk32("T6 dbg rdata", rd1, pre(2));

        fork
            agent(0, 40);
            agent(1, 40);
        join
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
